valvula_gotejamento_ctrl: RTL and testbench

//  Sequential valve driver directly downstream of the drip-irrigation decision logic.
//  - Consumes the combinational drip request (vg) and the supply alarm (alin).
//  - Debounces the request and enforces minimum-on, maximum-on and cooldown times.
//  - Drives the physical drip valve and reports state, timeout and fault status.

---
 rtl/valvula_gotejamento_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_valvula_gotejamento_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valvula_gotejamento_ctrl.sv
// -----------------------------------------------------------------------------
// valvula_gotejamento_ctrl
//   Sequential drip-valve driver that sits behind the drip decision logic.
//   It debounces the drip request, enforces minimum-on, maximum-on and
//   cooldown times, and holds the valve closed while the supply alarm is set.
//
//   Optional feature macro: DRIP_PULSE_EN
//     When defined, the valve pulses in OPEN (PULSE_ON ticks open, PULSE_OFF
//     ticks closed, starting open). The MIN_ON/MAX_ON timer still counts the
//     whole OPEN time. When undefined the valve is held at 1 throughout OPEN.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   vg       in   drip request
//   alin     in   supply alarm; 1 = abort and keep the valve closed
//   clr_to   in   one-cycle pulse clearing the sticky timeout flag
//   valve    out  registered valve drive
//   state    out  current state: IDLE=0, OPEN=1, COOL=2, FAULT=3
//   timeout  out  sticky flag, set when the maximum-on time expired
//   fault    out  1 while in FAULT
// -----------------------------------------------------------------------------
module valvula_gotejamento_ctrl #(
  parameter int PRESC     = 4,
  parameter int DEB_CYC   = 3,
  parameter int MIN_ON    = 2,
  parameter int MAX_ON    = 5,
  parameter int COOL      = 3,
  parameter int PULSE_ON  = 1,
  parameter int PULSE_OFF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vg,
  input  logic       alin,
  input  logic       clr_to,
  output logic       valve,
  output logic [1:0] state,
  output logic       timeout,
  output logic       fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_COOL  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

`ifdef DRIP_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  // Counter widths sized to the largest value each counter ever holds.
  localparam int PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int DW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int TMAX = (MAX_ON > COOL) ? MAX_ON : COOL;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PMAX = (PULSE_ON > PULSE_OFF) ? PULSE_ON : PULSE_OFF;
  localparam int QW   = $clog2(PMAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);
  localparam logic [TW:0]   MIN_T      = (TW+1)'(MIN_ON);
  localparam logic [TW:0]   MAX_T      = (TW+1)'(MAX_ON);
  localparam logic [TW:0]   COOL_T     = (TW+1)'(COOL);
  localparam logic [QW:0]   PON_T      = (QW+1)'(PULSE_ON);
  localparam logic [QW:0]   POFF_T     = (QW+1)'(PULSE_OFF);

  state_t          st_q, st_n;
  logic [PW-1:0]   presc_q, presc_n;
  logic [DW-1:0]   deb_q, deb_n;
  logic [TW-1:0]   tmr_q, tmr_n;
  logic [QW-1:0]   ph_tmr_q, ph_tmr_n;
  logic            phase_q, phase_n;
  logic            valve_n, timeout_n, fault_n;
  logic            tick, set_to;
  logic [TW:0]     t_el;
  logic [QW:0]     p_el;

  assign state = st_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= S_IDLE;
      presc_q  <= '0;
      deb_q    <= '0;
      tmr_q    <= '0;
      ph_tmr_q <= '0;
      phase_q  <= 1'b1;
      valve    <= 1'b0;
      timeout  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      st_q     <= st_n;
      presc_q  <= presc_n;
      deb_q    <= deb_n;
      tmr_q    <= tmr_n;
      ph_tmr_q <= ph_tmr_n;
      phase_q  <= phase_n;
      valve    <= valve_n;
      timeout  <= timeout_n;
      fault    <= fault_n;
    end
  end

  always_comb begin
    // The timebase only runs in the timed states; IDLE and FAULT hold it at 0
    // so nothing can wrap while waiting there.
    tick = ((st_q == S_OPEN) || (st_q == S_COOL)) && (presc_q == PRESC_LAST);
    // Ticks elapsed including the one completing on this edge.
    t_el = {1'b0, tmr_q} + {{TW{1'b0}}, tick};
    p_el = {1'b0, ph_tmr_q} + {{QW{1'b0}}, tick};

    st_n     = st_q;
    deb_n    = deb_q;
    presc_n  = '0;
    tmr_n    = '0;
    ph_tmr_n = ph_tmr_q;
    phase_n  = phase_q;
    set_to   = 1'b0;

    case (st_q)
      S_IDLE: begin
        if (vg && !alin) begin
          if (deb_q == DEB_LAST) begin
            st_n  = S_OPEN;
            deb_n = '0;
          end else begin
            deb_n = deb_q + 1'b1;
          end
        end else begin
          deb_n = '0;
        end
      end

      S_OPEN: begin
        presc_n = tick ? '0 : presc_q + 1'b1;
        tmr_n   = t_el[TW-1:0];
        if (PULSE_EN) begin
          // Phase changes always land on a tick, so the prescaler is
          // already restarting when the sub-period flips.
          if (phase_q && (p_el >= PON_T)) begin
            phase_n  = 1'b0;
            ph_tmr_n = '0;
          end else if (!phase_q && (p_el >= POFF_T)) begin
            phase_n  = 1'b1;
            ph_tmr_n = '0;
          end else begin
            ph_tmr_n = p_el[QW-1:0];
          end
        end
        if (alin) begin
          st_n = S_FAULT;
        end else if (t_el >= MAX_T) begin
          st_n   = S_COOL;
          set_to = 1'b1;
        end else if (!vg && (t_el >= MIN_T)) begin
          st_n = S_COOL;
        end
      end

      S_COOL: begin
        presc_n = tick ? '0 : presc_q + 1'b1;
        tmr_n   = t_el[TW-1:0];
        if (alin) begin
          st_n = S_FAULT;
        end else if (t_el >= COOL_T) begin
          st_n  = S_IDLE;
          deb_n = '0;
        end
      end

      S_FAULT: begin
        if (!alin) begin
          st_n = S_COOL;
        end
      end

      default: begin
        st_n = S_IDLE;
      end
    endcase

    // Every state change restarts the timebase and the pulse pattern, so a
    // period of N ticks is exactly N*PRESC cycles from the entry edge.
    if (st_n != st_q) begin
      presc_n  = '0;
      tmr_n    = '0;
      ph_tmr_n = '0;
      phase_n  = 1'b1;
    end

    // Expiry beats a simultaneous clear request.
    if (set_to) begin
      timeout_n = 1'b1;
    end else if (clr_to) begin
      timeout_n = 1'b0;
    end else begin
      timeout_n = timeout;
    end

    valve_n = (st_n == S_OPEN) && phase_n;
    fault_n = (st_n == S_FAULT);
  end

endmodule

// File: tb/tb_valvula_gotejamento_ctrl.sv
module tb_valvula_gotejamento_ctrl;

  localparam int PRESC     = 4;
  localparam int DEB_CYC   = 3;
  localparam int MIN_ON    = 2;
  localparam int MAX_ON    = 5;
  localparam int COOL      = 3;
  localparam int PULSE_ON  = 1;
  localparam int PULSE_OFF = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vg = 1'b0;
  logic       alin = 1'b0;
  logic       clr_to = 1'b0;
  logic       valve;
  logic [1:0] state;
  logic       timeout;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state number plus cycles spent in the current state.
  int   m_state;
  int   m_deb;
  int   m_cnt;
  logic m_to;
  logic m_valve;

  always #5 clk = ~clk;

  valvula_gotejamento_ctrl #(
    .PRESC(PRESC), .DEB_CYC(DEB_CYC), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON),
    .COOL(COOL), .PULSE_ON(PULSE_ON), .PULSE_OFF(PULSE_OFF)
  ) dut (
    .clk(clk), .rst(rst), .vg(vg), .alin(alin), .clr_to(clr_to),
    .valve(valve), .state(state), .timeout(timeout), .fault(fault)
  );

  task automatic model_reset();
    m_state = 0;
    m_deb   = 0;
    m_cnt   = 0;
    m_to    = 1'b0;
    m_valve = 1'b0;
  endtask

  // One clock edge of the rules, with times expressed in cycles.
  task automatic model_edge(input logic v, input logic a, input logic c);
    int   nxt;
    int   c1;
    logic set;
    nxt = m_state;
    c1  = m_cnt + 1;
    set = 1'b0;
    case (m_state)
      0: begin
        if (v && !a) begin
          m_deb = m_deb + 1;
          if (m_deb == DEB_CYC) begin
            nxt   = 1;
            m_deb = 0;
          end
        end else begin
          m_deb = 0;
        end
      end
      1: begin
        if (a) nxt = 3;
        else if (c1 >= MAX_ON * PRESC) begin
          nxt = 2;
          set = 1'b1;
        end else if (!v && c1 >= MIN_ON * PRESC) nxt = 2;
      end
      2: begin
        if (a) nxt = 3;
        else if (c1 >= COOL * PRESC) begin
          nxt   = 0;
          m_deb = 0;
        end
      end
      default: if (!a) nxt = 2;
    endcase
    m_cnt   = (nxt != m_state) ? 0 : c1;
    m_state = nxt;
    if (set) m_to = 1'b1;
    else if (c) m_to = 1'b0;
    m_valve = (m_state == 1);
`ifdef DRIP_PULSE_EN
    if (m_state == 1) m_valve = ((m_cnt / PRESC) % (PULSE_ON + PULSE_OFF)) < PULSE_ON;
`endif
  endtask

  function automatic logic [4:0] m_vec();
    return {2'(m_state), m_valve, m_to, (m_state == 3)};
  endfunction

  // Drive inputs, advance one edge, update the model, settle.
  task automatic step(input logic v, input logic a, input logic c);
    vg     = v;
    alin   = a;
    clr_to = c;
    @(posedge clk);
    model_edge(v, a, c);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    vg     = 1'b0;
    alin   = 1'b0;
    clr_to = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vg  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({state, valve, timeout, fault} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_state: got %b required %b", {state, valve, timeout, fault}, 5'b0);
      end
    end
    do_reset();
  endtask

  task automatic test_hold_open();
    int hi;
    int exp_hi;
`ifdef DRIP_PULSE_EN
    exp_hi = 12;
`else
    exp_hi = 20;
`endif
    hi = 0;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({state, valve, timeout, fault} !== m_vec()) begin
        n_fail++;
        $display("FAIL hold_open cyc %0d: got %b required %b", i, {state, valve, timeout, fault}, m_vec());
      end
      if (i <= 30 && valve === 1'b1) hi++;
      if (i == 3) begin
        n_tests++;
        if (valve !== 1'b1 || state !== 2'd1) begin
          n_fail++;
          $display("FAIL open_after_3: valve %b state %0d required 1/1", valve, state);
        end
      end
      if (i == 23) begin
        n_tests++;
        if (valve !== 1'b0 || state !== 2'd2 || timeout !== 1'b1) begin
          n_fail++;
          $display("FAIL max_on_expiry: valve %b state %0d timeout %b required 0/2/1", valve, state, timeout);
        end
      end
      if (i == 35) begin
        n_tests++;
        if (state !== 2'd0) begin
          n_fail++;
          $display("FAIL cool_to_idle: state %0d required 0", state);
        end
      end
      if (i == 38) begin
        n_tests++;
        if (state !== 2'd1) begin
          n_fail++;
          $display("FAIL reopen: state %0d required 1", state);
        end
      end
    end
    n_tests++;
    if (hi != exp_hi) begin
      n_fail++;
      $display("FAIL open_length: got %0d cycles required %0d", hi, exp_hi);
    end
  endtask

  task automatic test_short_request();
    logic seen;
    seen = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      if (valve !== 1'b0 || state !== 2'd0) seen = 1'b1;
      n_tests++;
      if ({state, valve, timeout, fault} !== m_vec()) begin
        n_fail++;
        $display("FAIL short_req cyc %0d: got %b required %b", i, {state, valve, timeout, fault}, m_vec());
      end
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL short_req_idle: left IDLE flag %b required 0", seen);
    end
  endtask

  task automatic test_min_on();
    int hi;
    int exp_hi;
`ifdef DRIP_PULSE_EN
    exp_hi = 4;
`else
    exp_hi = 8;
`endif
    hi = 0;
    do_reset();
    for (int i = 1; i <= 27; i++) begin
      step((i <= 7) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      if (valve === 1'b1) hi++;
      n_tests++;
      if ({state, valve, timeout, fault} !== m_vec()) begin
        n_fail++;
        $display("FAIL min_on cyc %0d: got %b required %b", i, {state, valve, timeout, fault}, m_vec());
      end
      if (i == 11) begin
        n_tests++;
        if (state !== 2'd2 || timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL min_on_close: state %0d timeout %b required 2/0", state, timeout);
        end
      end
    end
    n_tests++;
    if (hi != exp_hi) begin
      n_fail++;
      $display("FAIL min_on_length: got %0d cycles required %0d", hi, exp_hi);
    end
  endtask

  task automatic test_alarm();
    do_reset();
    for (int i = 1; i <= 26; i++) begin
      step(1'b1, (i >= 9 && i <= 11) ? 1'b1 : 1'b0, 1'b0);
      n_tests++;
      if ({state, valve, timeout, fault} !== m_vec()) begin
        n_fail++;
        $display("FAIL alarm cyc %0d: got %b required %b", i, {state, valve, timeout, fault}, m_vec());
      end
      if (i == 9) begin
        n_tests++;
        if (valve !== 1'b0 || fault !== 1'b1 || state !== 2'd3) begin
          n_fail++;
          $display("FAIL alarm_abort: valve %b fault %b state %0d required 0/1/3", valve, fault, state);
        end
      end
      if (i == 12) begin
        n_tests++;
        if (state !== 2'd2 || fault !== 1'b0) begin
          n_fail++;
          $display("FAIL fault_to_cool: state %0d fault %b required 2/0", state, fault);
        end
      end
      if (i == 24) begin
        n_tests++;
        if (state !== 2'd0) begin
          n_fail++;
          $display("FAIL fault_cool_idle: state %0d required 0", state);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 41; i++) begin
      step(1'b1, 1'b0, 1'b0);
      n_tests++;
      if ({state, valve, timeout, fault} !== m_vec()) begin
        n_fail++;
        $display("FAIL pre_reset cyc %0d: got %b required %b", i, {state, valve, timeout, fault}, m_vec());
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({state, valve, timeout, fault} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b required %b", {state, valve, timeout, fault}, 5'b0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clr_same_edge();
    do_reset();
    for (int i = 1; i <= 22; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    n_tests++;
    if (timeout !== 1'b1 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL set_beats_clr: timeout %b state %0d required 1/2", timeout, state);
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({state, valve, timeout, fault} !== m_vec() || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_to: got %b required %b", {state, valve, timeout, fault}, m_vec());
    end
  endtask

  task automatic test_random();
    logic v;
    logic a;
    logic c;
    v = 1'b0;
    a = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) v = ~v;
      if ($urandom_range(0, 23) == 0) a = ~a;
      c = ($urandom_range(0, 15) == 0);
      step(v, a, c);
      n_tests++;
      if ({state, valve, timeout, fault} !== m_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b required %b", i, {state, valve, timeout, fault}, m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_open();
    test_short_request();
    test_min_on();
    test_alarm();
    test_async_reset();
    test_clr_same_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
